// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// bin_to_bcd_seq : sequential shift-add-3 binary to packed BCD converter
// Rev 1.0 : initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 10,
  parameter int DIGITS    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  overflow
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int c_CMP_W = (BIN_WIDTH > 32) ? BIN_WIDTH : 32;

  localparam logic [c_CMP_W-1:0] c_LIMIT     = c_CMP_W'(10 ** DIGITS);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'(BIN_WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_BCD_W-1:0] c_BCD_SAT   = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0]  c_BLANK_RST = ~(DIGITS'(1'b1));

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SHIFT  = 2'd1;
  localparam logic [1:0] c_ST_FINISH = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_accept;
  logic                 w_shift_en;
  logic                 w_finish;

  logic [BIN_WIDTH-1:0] r_shift;
  logic [c_BCD_W-1:0]   r_scratch;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_ovf_pend;

  logic                 r_busy;
  logic                 r_done;
  logic [c_BCD_W-1:0]   r_bcd;
  logic [DIGITS-1:0]    r_blank;
  logic                 r_ovf;

  logic [c_BCD_W-1:0]   w_adj;
  logic [DIGITS-1:0]    w_blank;
  logic                 w_run_zero;
  logic [c_CMP_W-1:0]   w_bin_ext;

  assign w_bin_ext = c_CMP_W'(bin_in);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (start) w_state_nxt = c_ST_SHIFT;
      c_ST_SHIFT:  if (r_cnt == c_CNT_ONE) w_state_nxt = c_ST_FINISH;
      c_ST_FINISH: w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State-decoded datapath controls
  always_comb begin
    w_accept   = 1'b0;
    w_shift_en = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      c_ST_IDLE:   w_accept   = start;
      c_ST_SHIFT:  w_shift_en = 1'b1;
      c_ST_FINISH: w_finish   = 1'b1;
      default:     w_accept   = 1'b0;
    endcase
  end

  // Add 3 to any nibble >= 5 so the following left shift carries correctly into the next digit
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ? r_scratch[4*g +: 4] + 4'd3
                                                             : r_scratch[4*g +: 4];
    end
  endgenerate

  always_comb begin
    w_blank    = '0;
    w_run_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_run_zero = w_run_zero & (r_scratch[4*i +: 4] == 4'd0);
      w_blank[i] = w_run_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_blank    <= c_BLANK_RST;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift    <= bin_in;
        r_scratch  <= '0;
        r_cnt      <= c_CNT_LOAD;
        r_ovf_pend <= (w_bin_ext >= c_LIMIT);
        r_busy     <= 1'b1;
      end
      if (w_shift_en) begin
        {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
        r_cnt                <= r_cnt - c_CNT_ONE;
      end
      if (w_finish) begin
        r_bcd   <= r_ovf_pend ? c_BCD_SAT : r_scratch;
        r_blank <= r_ovf_pend ? '0 : w_blank;
        r_ovf   <= r_ovf_pend;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign bcd_out   = r_bcd;
  assign blank_out = r_blank;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// tb_bin_to_bcd_seq : directed self-checking bench for bin_to_bcd_seq
// Rev 1.0 : initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [2:0]  blank_out;
  logic        overflow;

  int n_tests;
  int n_fail;

  bin_to_bcd_seq #(.BIN_WIDTH(10), .DIGITS(3)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .blank_out (blank_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one conversion and report how many edges after the accepting edge done appeared (0 = never)
  task automatic run_conv(input logic [9:0] v, output int edges);
    edges = 0;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = ~v;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (bcd_out !== 12'h000)  begin n_fail++; $display("FAIL reset_bcd: got %h expected 000", bcd_out); end
    n_tests++; if (blank_out !== 3'b110) begin n_fail++; $display("FAIL reset_blank: got %b expected 110", blank_out); end
    n_tests++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_zero();
    int e;
    run_conv(10'd0, e);
    n_tests++; if (e != 11)              begin n_fail++; $display("FAIL zero_latency: got %0d expected 11", e); end
    n_tests++; if (bcd_out !== 12'h000)  begin n_fail++; $display("FAIL zero_bcd: got %h expected 000", bcd_out); end
    n_tests++; if (blank_out !== 3'b110) begin n_fail++; $display("FAIL zero_blank: got %b expected 110", blank_out); end
    n_tests++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL zero_ovf: got %b expected 0", overflow); end
    n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0)        begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", done); end
  endtask

  task automatic test_small_values();
    int e;
    run_conv(10'd42, e);
    n_tests++; if (bcd_out !== 12'h042)  begin n_fail++; $display("FAIL v42_bcd: got %h expected 042", bcd_out); end
    n_tests++; if (blank_out !== 3'b100) begin n_fail++; $display("FAIL v42_blank: got %b expected 100", blank_out); end
    run_conv(10'd7, e);
    n_tests++; if (bcd_out !== 12'h007)  begin n_fail++; $display("FAIL v7_bcd: got %h expected 007", bcd_out); end
    n_tests++; if (blank_out !== 3'b110) begin n_fail++; $display("FAIL v7_blank: got %b expected 110", blank_out); end
  endtask

  task automatic test_three_digit();
    int e;
    run_conv(10'd305, e);
    n_tests++; if (bcd_out !== 12'h305)  begin n_fail++; $display("FAIL v305_bcd: got %h expected 305", bcd_out); end
    n_tests++; if (blank_out !== 3'b000) begin n_fail++; $display("FAIL v305_blank: got %b expected 000", blank_out); end
    n_tests++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL v305_ovf: got %b expected 0", overflow); end
    run_conv(10'd100, e);
    n_tests++; if (bcd_out !== 12'h100)  begin n_fail++; $display("FAIL v100_bcd: got %h expected 100", bcd_out); end
    n_tests++; if (blank_out !== 3'b000) begin n_fail++; $display("FAIL v100_blank: got %b expected 000", blank_out); end
    run_conv(10'd999, e);
    n_tests++; if (bcd_out !== 12'h999)  begin n_fail++; $display("FAIL v999_bcd: got %h expected 999", bcd_out); end
    n_tests++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL v999_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    int e;
    run_conv(10'd1023, e);
    n_tests++; if (bcd_out !== 12'h999)  begin n_fail++; $display("FAIL v1023_bcd: got %h expected 999", bcd_out); end
    n_tests++; if (blank_out !== 3'b000) begin n_fail++; $display("FAIL v1023_blank: got %b expected 000", blank_out); end
    n_tests++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL v1023_ovf: got %b expected 1", overflow); end
    run_conv(10'd1000, e);
    n_tests++; if (bcd_out !== 12'h999)  begin n_fail++; $display("FAIL v1000_bcd: got %h expected 999", bcd_out); end
    n_tests++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL v1000_ovf: got %b expected 1", overflow); end
    run_conv(10'd5, e);
    n_tests++; if (bcd_out !== 12'h005)  begin n_fail++; $display("FAIL v5_bcd: got %h expected 005", bcd_out); end
    n_tests++; if (blank_out !== 3'b110) begin n_fail++; $display("FAIL v5_blank: got %b expected 110", blank_out); end
    n_tests++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL v5_ovf: got %b expected 0", overflow); end
  endtask

  // Previous result is 005; a start pulse while busy must be ignored
  task automatic test_busy_ignore();
    int dones;
    int first;
    dones = 0;
    first = 0;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      start  = (c == 0) || (c == 4);
      bin_in = (c == 4) ? 10'd111 : 10'd305;
      @(posedge clk);
      #1;
      if (c > 0 && done) begin
        dones++;
        if (first == 0) first = c;
      end
      if (c == 5) begin
        n_tests++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL busy_mid: got %b expected 1", busy); end
        n_tests++; if (bcd_out !== 12'h005) begin n_fail++; $display("FAIL hold_mid: got %h expected 005", bcd_out); end
      end
      if (c == 11) begin
        n_tests++; if (bcd_out !== 12'h305) begin n_fail++; $display("FAIL ignore_bcd: got %h expected 305", bcd_out); end
      end
    end
    start = 1'b0;
    n_tests++; if (dones != 1)  begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    n_tests++; if (first != 11) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 11", first); end
  endtask

  task automatic test_back_to_back();
    int e;
    run_conv(10'd42, e);
    n_tests++; if (bcd_out !== 12'h042) begin n_fail++; $display("FAIL b2b_first_bcd: got %h expected 042", bcd_out); end
    @(negedge clk);
    n_tests++; if (done !== 1'b1)       begin n_fail++; $display("FAIL b2b_done_window: got %b expected 1", done); end
    start  = 1'b1;
    bin_in = 10'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_tests++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
    e = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        e = c;
        break;
      end
    end
    n_tests++; if (e != 11)             begin n_fail++; $display("FAIL b2b_latency: got %0d expected 11", e); end
    n_tests++; if (bcd_out !== 12'h007) begin n_fail++; $display("FAIL b2b_second_bcd: got %h expected 007", bcd_out); end
  endtask

  task automatic test_reset_abort();
    int e;
    int dones;
    run_conv(10'd42, e);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 10'd305;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (bcd_out !== 12'h042)  begin n_fail++; $display("FAIL abort_hold: got %h expected 042", bcd_out); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (bcd_out !== 12'h000)  begin n_fail++; $display("FAIL abort_bcd: got %h expected 000", bcd_out); end
    n_tests++; if (blank_out !== 3'b110) begin n_fail++; $display("FAIL abort_blank: got %b expected 110", blank_out); end
    n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    n_tests++; if (dones != 0)           begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    run_conv(10'd9, e);
    n_tests++; if (e != 11)              begin n_fail++; $display("FAIL after_abort_latency: got %0d expected 11", e); end
    n_tests++; if (bcd_out !== 12'h009)  begin n_fail++; $display("FAIL after_abort_bcd: got %h expected 009", bcd_out); end
    n_tests++; if (blank_out !== 3'b110) begin n_fail++; $display("FAIL after_abort_blank: got %b expected 110", blank_out); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    bin_in  = '0;
    test_reset();
    test_zero();
    test_small_values();
    test_three_digit();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
